// File: rtl/serial_adder_ctrl_if.sv
// Handshake/operand/result bundle for serial_adder_ctrl.
// The zero port exists only when SERIAL_ADDER_ZERO_FLAG_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  ready, done, result, cout, overflow, zero
    );
    modport slave (
        input  start, sub, a, b,
        output ready, done, result, cout, overflow, zero
    );
`else
    modport master (
        output start, sub, a, b,
        input  ready, done, result, cout, overflow
    );
    modport slave (
        input  start, sub, a, b,
        output ready, done, result, cout, overflow
    );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, one bit per clock, LSB first.
// Optional zero flag enabled by defining SERIAL_ADDER_ZERO_FLAG_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // The one and only arithmetic element: {carry_out, sum}.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    state_t           state_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sum_d;
    logic             carry_d;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    logic             sticky_q;
    logic             zero_q;
`endif

    always_comb begin
        {carry_d, sum_d} = full_adder(sa_q[0], sb_q[0], carry_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            sa_q     <= '0;
            sb_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Subtraction runs as A + ~B with the initial carry supplying the +1.
                        sa_q    <= bus.a;
                        sb_q    <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
                        sticky_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    result_q <= {sum_d, result_q[WIDTH-1:1]};
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    carry_q  <= carry_d;
                    cnt_q    <= cnt_q + 1'b1;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
                    sticky_q <= sticky_q | sum_d;
`endif
                    if (cnt_q == LAST_BIT) begin
                        // carry_q still holds the carry into the MSB here.
                        ovf_q   <= carry_q ^ carry_d;
                        cout_q  <= carry_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
                        zero_q  <= ~(sticky_q | sum_d);
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    assign bus.zero     = zero_q;
`endif

endmodule
